// File: rtl/util_timestamp_pkg.sv
// Shared definitions for the timestamp insertion stage and the packet gate.
package util_timestamp_pkg;

    localparam int TS_EVERY_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_ALIGN = 2'd0,
        ST_PASS  = 2'd1,
        ST_DROP  = 2'd2
    } ts_gate_state_t;

endpackage

// File: rtl/util_timestamp_packet_gate.sv
// Packet gate between the timestamp-insertion stage and the DMAC FIFO write port.
// After a DMAC overflow it discards the rest of the damaged packet, so that the
// DMA buffer always restarts on a timestamp header.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_ALIGN | timestamping off, or waiting for the first word (the header)
//  ST_PASS  | aligned; every word is forwarded
//  ST_DROP  | discarding the damaged packet until the next header
module util_timestamp_packet_gate
    import util_timestamp_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int DROP_CNT_WIDTH = 32
) (
    input  logic                      dma_clk,
    input  logic                      dma_rst,
    input  logic [TS_EVERY_WIDTH-1:0] timestamp_every,
    input  logic                      in_wr_en,
    input  logic                      in_wr_sync,
    input  logic [DATA_WIDTH-1:0]     in_wr_data,
    output logic                      in_wr_overflow,
    output logic                      out_wr_en,
    output logic                      out_wr_sync,
    output logic [DATA_WIDTH-1:0]     out_wr_data,
    input  logic                      out_wr_overflow,
    output logic                      dropping,
    output logic [DROP_CNT_WIDTH-1:0] dropped_packets
);

    // One extra bit so that pos can never wrap before reaching every_q.
    localparam int POS_WIDTH = TS_EVERY_WIDTH + 1;

    ts_gate_state_t             state, state_nxt;
    logic [POS_WIDTH-1:0]       pos, pos_nxt, pos_adv;
    logic [TS_EVERY_WIDTH-1:0]  every_q, every_nxt;
    logic                       fwd;
    logic                       drop_nxt;
    logic                       cnt_inc;
    logic                       boundary_word;
    logic                       ts_off;

    // Packet position bookkeeping shared by all states.
    always_comb begin
        pos_adv       = (pos == {1'b0, every_q}) ? '0 : pos + POS_WIDTH'(1);
        boundary_word = in_wr_en && (pos == '0);
        ts_off        = (timestamp_every == '0);
    end

    // Next-state, forwarding decision and position tracking.
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        every_nxt = every_q;
        fwd       = 1'b0;
        drop_nxt  = dropping;
        cnt_inc   = 1'b0;

        case (state)
            ST_ALIGN: begin
                // Overflow is only echoed upstream here; nothing is dropped.
                every_nxt = timestamp_every;
                fwd       = in_wr_en;
                pos_nxt   = '0;
                drop_nxt  = 1'b0;
                if (!ts_off && in_wr_en) begin
                    pos_nxt   = POS_WIDTH'(1);
                    state_nxt = ST_PASS;
                end
            end

            ST_PASS: begin
                if (boundary_word && ts_off) begin
                    // Timestamping switched off at a header: fall back to pass-through.
                    every_nxt = '0;
                    pos_nxt   = '0;
                    fwd       = 1'b1;
                    state_nxt = ST_ALIGN;
                end else begin
                    if (boundary_word) begin
                        every_nxt = timestamp_every;
                    end
                    if (in_wr_en) begin
                        pos_nxt = pos_adv;
                    end
                    if (out_wr_overflow) begin
                        // The word registered this cycle is already part of the loss.
                        state_nxt = ST_DROP;
                        drop_nxt  = 1'b1;
                        cnt_inc   = 1'b1;
                    end else begin
                        fwd = in_wr_en;
                    end
                end
            end

            ST_DROP: begin
                // Overflow seen here belongs to writes issued before DROP; not recounted.
                if (boundary_word) begin
                    fwd      = 1'b1;
                    drop_nxt = 1'b0;
                    if (ts_off) begin
                        every_nxt = '0;
                        pos_nxt   = '0;
                        state_nxt = ST_ALIGN;
                    end else begin
                        every_nxt = timestamp_every;
                        pos_nxt   = POS_WIDTH'(1);
                        state_nxt = ST_PASS;
                    end
                end else if (in_wr_en) begin
                    pos_nxt = pos_adv;
                end
            end

            default: begin
                state_nxt = ST_ALIGN;
                pos_nxt   = '0;
                drop_nxt  = 1'b0;
            end
        endcase
    end

    // State, output registers and the saturating drop counter.
    always_ff @(posedge dma_clk or posedge dma_rst) begin
        if (dma_rst) begin
            state           <= ST_ALIGN;
            pos             <= '0;
            every_q         <= '0;
            out_wr_en       <= 1'b0;
            out_wr_sync     <= 1'b0;
            out_wr_data     <= '0;
            in_wr_overflow  <= 1'b0;
            dropping        <= 1'b0;
            dropped_packets <= '0;
        end else begin
            state          <= state_nxt;
            pos            <= pos_nxt;
            every_q        <= every_nxt;
            out_wr_en      <= fwd;
            out_wr_sync    <= fwd & in_wr_sync;
            in_wr_overflow <= out_wr_overflow;
            dropping       <= drop_nxt;
            if (fwd) begin
                out_wr_data <= in_wr_data;
            end
            if (cnt_inc && (dropped_packets != '1)) begin
                dropped_packets <= dropped_packets + DROP_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_util_timestamp_packet_gate.sv
// Scoreboard bench for util_timestamp_packet_gate: expected forwarded words are
// queued as stimulus is driven and popped as the gate writes them out.
module tb_util_timestamp_packet_gate;

    logic        dma_clk;
    logic        dma_rst;
    logic [31:0] timestamp_every;
    logic        in_wr_en;
    logic        in_wr_sync;
    logic [63:0] in_wr_data;
    logic        in_wr_overflow;
    logic        out_wr_en;
    logic        out_wr_sync;
    logic [63:0] out_wr_data;
    logic        out_wr_overflow;
    logic        dropping;
    logic [31:0] dropped_packets;

    int n_tests = 0;
    int n_fail  = 0;
    int drop_seen = 0;
    logic [64:0] exp_q[$];

    util_timestamp_packet_gate #(
        .DATA_WIDTH(64),
        .DROP_CNT_WIDTH(32)
    ) dut (
        .dma_clk(dma_clk),
        .dma_rst(dma_rst),
        .timestamp_every(timestamp_every),
        .in_wr_en(in_wr_en),
        .in_wr_sync(in_wr_sync),
        .in_wr_data(in_wr_data),
        .in_wr_overflow(in_wr_overflow),
        .out_wr_en(out_wr_en),
        .out_wr_sync(out_wr_sync),
        .out_wr_data(out_wr_data),
        .out_wr_overflow(out_wr_overflow),
        .dropping(dropping),
        .dropped_packets(dropped_packets)
    );

    initial dma_clk = 1'b0;
    always #5 dma_clk = ~dma_clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Output monitor: every forwarded word must match the head of the queue.
    always @(negedge dma_clk) begin
        if (!dma_rst) begin
            if (dropping) drop_seen++;
            if (out_wr_en) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_write", out_wr_data, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    logic [64:0] e;
                    e = exp_q.pop_front();
                    check_val("out_data", out_wr_data, e[63:0]);
                    check_val("out_sync", {63'd0, out_wr_sync}, {63'd0, e[64]});
                end
            end else begin
                check_val("sync_idle", {63'd0, out_wr_sync}, 64'd0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_en"},   {63'd0, out_wr_en}, 64'd0);
        check_val({tag, "_sync"}, {63'd0, out_wr_sync}, 64'd0);
        check_val({tag, "_data"}, out_wr_data, 64'd0);
        check_val({tag, "_ovf"},  {63'd0, in_wr_overflow}, 64'd0);
        check_val({tag, "_drop"}, {63'd0, dropping}, 64'd0);
        check_val({tag, "_cnt"},  {32'd0, dropped_packets}, 64'd0);
    endtask

    // Asynchronous reset, checked before any clock edge can occur.
    task automatic do_reset();
        dma_rst = 1'b1;
        #1;
        check_reset_outputs("rst");
        exp_q.delete();
        in_wr_en        = 1'b0;
        in_wr_sync      = 1'b0;
        in_wr_data      = '0;
        out_wr_overflow = 1'b0;
        @(posedge dma_clk);
        #1;
        dma_rst   = 1'b0;
        drop_seen = 0;
    endtask

    task automatic send(input logic en, input logic [63:0] d, input logic s, input logic ovf);
        in_wr_en        = en;
        in_wr_data      = d;
        in_wr_sync      = s;
        out_wr_overflow = ovf;
        @(posedge dma_clk);
        #1;
        check_val("ovf_echo", {63'd0, in_wr_overflow}, {63'd0, ovf});
    endtask

    // Drive n words; overflow pulses with word ovf0/ovf1; words in [dlo,dhi]
    // ranges are expected to be discarded by the gate.
    task automatic run_stream(input logic [7:0] tid, input int n,
                              input int ts0, input int ts1, input int ts_sw, input int gap,
                              input int ovf0, input int ovf1,
                              input int dlo0, input int dhi0, input int dlo1, input int dhi1,
                              input int exp_cnt, input logic exp_drop_end);
        for (int i = 0; i < n; i++) begin
            logic [63:0] d;
            logic        s;
            logic        ovf;
            logic        dropped;
            timestamp_every = (i < ts_sw) ? ts0[31:0] : ts1[31:0];
            d       = {tid, 24'h0, 32'(i)};
            s       = ((i % 3) == 0);
            ovf     = (i == ovf0) || (i == ovf1);
            dropped = (i >= dlo0 && i <= dhi0) || (i >= dlo1 && i <= dhi1);
            if (!dropped) exp_q.push_back({s, d});
            send(1'b1, d, s, ovf);
            if (gap != 0 && (i % gap) == gap - 1) send(1'b0, 64'd0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 3; k++) send(1'b0, 64'd0, 1'b0, 1'b0);
        check_val("queue_empty", 64'(exp_q.size()), 64'd0);
        check_val("drop_count", {32'd0, dropped_packets}, 64'(exp_cnt));
        check_val("dropping_end", {63'd0, dropping}, {63'd0, exp_drop_end});
        check_val("drop_seen", {63'd0, drop_seen > 0}, {63'd0, exp_cnt != 0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        dma_rst         = 1'b1;
        timestamp_every = '0;
        in_wr_en        = 1'b0;
        in_wr_sync      = 1'b0;
        in_wr_data      = '0;
        out_wr_overflow = 1'b0;

        // 1: pass-through, overflow only echoed
        do_reset();
        run_stream(8'h01, 12, 0, 0, 0, 0, 4, -1, 1, 0, 1, 0, 0, 1'b0);

        // 2: aligned packets, nothing dropped
        do_reset();
        run_stream(8'h02, 15, 4, 4, 0, 0, -1, -1, 1, 0, 1, 0, 0, 1'b0);

        // 3: overflow on D2 of packet 1, idle gaps in the stream
        do_reset();
        run_stream(8'h03, 15, 4, 4, 0, 3, 7, -1, 7, 9, 1, 0, 1, 1'b0);

        // 4: overflow with header H1 presented
        do_reset();
        run_stream(8'h04, 15, 4, 4, 0, 0, 5, -1, 5, 9, 1, 0, 1, 1'b0);

        // 5: every 4->2 mid-packet; drops in the following short packets
        do_reset();
        run_stream(8'h05, 14, 4, 2, 2, 0, 6, 9, 6, 7, 9, 10, 2, 1'b0);

        // 6: reset in the middle of DROP, then a clean re-alignment
        do_reset();
        run_stream(8'h06, 3, 4, 4, 0, 0, 2, -1, 2, 2, 1, 0, 1, 1'b1);
        check_val("pre_rst_cnt", {32'd0, dropped_packets}, 64'd1);
        do_reset();
        run_stream(8'h07, 10, 4, 4, 0, 0, 2, -1, 2, 4, 1, 0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
